// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Purpose  : Clocked ALU with registered result and {C,Z,N,V} flags.
//             Single-cycle logic/arithmetic ops. Multi-cycle one-bit-per-
//             clock shifts and shift-add multiply behind start/busy/done.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] inp_0,
  input  logic [WIDTH-1:0] inp_1,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_hi,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] c_op_pass_b0 = 4'h1;
  localparam logic [3:0] c_op_pass_b1 = 4'h2;
  localparam logic [3:0] c_op_and     = 4'h3;
  localparam logic [3:0] c_op_or      = 4'h4;
  localparam logic [3:0] c_op_xor     = 4'h5;
  localparam logic [3:0] c_op_not_b   = 4'h6;
  localparam logic [3:0] c_op_sub     = 4'h7;
  localparam logic [3:0] c_op_adc     = 4'h8;
  localparam logic [3:0] c_op_shl     = 4'h9;
  localparam logic [3:0] c_op_shr     = 4'ha;
  localparam logic [3:0] c_op_add     = 4'hb;
  localparam logic [3:0] c_op_mul     = 4'hc;
  localparam logic [3:0] c_op_cmp     = 4'hd;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_MUL   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0]   r_res;
  logic [WIDTH-1:0]   r_res_hi;
  logic [3:0]         r_flags;
  logic               r_done;
  logic [WIDTH-1:0]   r_a;        // shift register / multiplicand
  logic [2*WIDTH-1:0] r_prod;     // {partial sum, remaining multiplier bits}
  logic [CNT_W-1:0]   r_cnt;
  logic               r_op_shl;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_adc;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_val;
  logic               w_c;
  logic               w_v;
  logic               w_wr_res;
  logic [3:0]         w_flags;
  logic [CNT_W-1:0]   w_k;
  logic               w_go_shift;
  logic               w_go_mul;
  logic [WIDTH-1:0]   w_sh_nxt;
  logic               w_sh_out;
  logic [WIDTH:0]     w_mul_add;
  logic [2*WIDTH-1:0] w_prod_nxt;

  // Single-cycle result and flags straight from the issuing operands
  always_comb begin
    w_sum    = {1'b0, inp_0} + {1'b0, inp_1};
    w_adc    = w_sum + {{WIDTH{1'b0}}, r_flags[3]};
    w_diff   = {1'b0, inp_0} - {1'b0, inp_1};
    w_val    = inp_0;
    w_c      = r_flags[3];
    w_v      = 1'b0;
    w_wr_res = 1'b1;
    case (sel)
      c_op_pass_b0, c_op_pass_b1: w_val = inp_1;
      c_op_and:   w_val = inp_0 & inp_1;
      c_op_or:    w_val = inp_0 | inp_1;
      c_op_xor:   w_val = inp_0 ^ inp_1;
      c_op_not_b: w_val = ~inp_1;
      c_op_sub, c_op_cmp: begin
        w_val    = w_diff[WIDTH-1:0];
        w_c      = w_diff[WIDTH];
        w_v      = (inp_0[WIDTH-1] != inp_1[WIDTH-1]) &&
                   (w_diff[WIDTH-1] != inp_0[WIDTH-1]);
        w_wr_res = (sel != c_op_cmp);
      end
      c_op_adc: begin
        w_val = w_adc[WIDTH-1:0];
        w_c   = w_adc[WIDTH];
        w_v   = (inp_0[WIDTH-1] == inp_1[WIDTH-1]) &&
                (w_adc[WIDTH-1] != inp_0[WIDTH-1]);
      end
      c_op_add: begin
        w_val = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (inp_0[WIDTH-1] == inp_1[WIDTH-1]) &&
                (w_sum[WIDTH-1] != inp_0[WIDTH-1]);
      end
      // zero-distance shift: behaves as a pass of A with C cleared
      c_op_shl, c_op_shr: w_c = 1'b0;
      default: w_val = inp_0;
    endcase
    w_flags = {w_c, (w_val == '0), w_val[WIDTH-1], w_v};
  end

  // Shift distance saturates at WIDTH; decide which ops leave IDLE
  always_comb begin
    if (inp_1 > WIDTH'(WIDTH)) begin
      w_k = CNT_W'(WIDTH);
    end else begin
      w_k = inp_1[CNT_W-1:0];
    end
    w_go_mul   = (sel == c_op_mul);
    w_go_shift = ((sel == c_op_shl) || (sel == c_op_shr)) && (w_k != '0);
  end

  // One shift step and one shift-add multiply step from the working regs
  always_comb begin
    if (r_op_shl) begin
      w_sh_nxt = {r_a[WIDTH-2:0], 1'b0};
      w_sh_out = r_a[WIDTH-1];
    end else begin
      w_sh_nxt = {1'b0, r_a[WIDTH-1:1]};
      w_sh_out = r_a[0];
    end
    if (r_prod[0]) begin
      w_mul_add = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_a};
    end else begin
      w_mul_add = {1'b0, r_prod[2*WIDTH-1:WIDTH]};
    end
    w_prod_nxt = {w_mul_add, r_prod[WIDTH-1:1]};
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: multi-cycle ops return to IDLE on their final step
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && w_go_mul) begin
          w_state_nxt = S_MUL;
        end else if (start && w_go_shift) begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT, S_MUL: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, result/flag commit and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res    <= '0;
      r_res_hi <= '0;
      r_flags  <= '0;
      r_done   <= 1'b0;
      r_a      <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_op_shl <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a      <= inp_0;
            r_op_shl <= (sel == c_op_shl);
            if (w_go_mul) begin
              r_prod <= {{WIDTH{1'b0}}, inp_1};
              r_cnt  <= CNT_W'(WIDTH);
            end else if (w_go_shift) begin
              r_cnt <= w_k;
            end else begin
              if (w_wr_res) begin
                r_res <= w_val;
              end
              r_flags <= w_flags;
              r_done  <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          r_a   <= w_sh_nxt;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            // C is the bit that left the register on this final step
            r_res   <= w_sh_nxt;
            r_flags <= {w_sh_out, (w_sh_nxt == '0), w_sh_nxt[WIDTH-1], 1'b0};
            r_done  <= 1'b1;
          end
        end
        S_MUL: begin
          r_prod <= w_prod_nxt;
          r_cnt  <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_res    <= w_prod_nxt[WIDTH-1:0];
            r_res_hi <= w_prod_nxt[2*WIDTH-1:WIDTH];
            r_flags  <= {(w_prod_nxt[2*WIDTH-1:WIDTH] != '0), (w_prod_nxt == '0),
                         w_prod_nxt[WIDTH-1], 1'b0};
            r_done   <= 1'b1;
          end
        end
        default: r_done <= 1'b0;
      endcase
    end
  end

  assign res    = r_res;
  assign res_hi = r_res_hi;
  assign flags  = r_flags;
  assign done   = r_done;
  assign busy   = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq
//  Purpose  : Scoreboard bench for alu_seq at WIDTH=8 and WIDTH=16.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic [3:0]  flags;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start8, start16;
  logic [3:0]  sel8, sel16;
  logic [7:0]  a8, b8, res8, hi8;
  logic [15:0] a16, b16, res16, hi16;
  logic [3:0]  flags8, flags16;
  logic        busy8, busy16, done8, done16;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t q8[$];
  exp_t q16[$];
  exp_t m8, m16;
  exp_t e8, e16;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sel(sel8), .inp_0(a8), .inp_1(b8),
    .res(res8), .res_hi(hi8), .flags(flags8), .busy(busy8), .done(done8)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .sel(sel16), .inp_0(a16), .inp_1(b16),
    .res(res16), .res_hi(hi16), .flags(flags16), .busy(busy16), .done(done16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint sx(input int w, input logic [31:0] v);
    longint x;
    x = longint'({32'h0, v});
    if (v[w-1]) x = x - (longint'(1) << w);
    return x;
  endfunction

  // Behavioural reference: returns the committed state after one op
  function automatic exp_t model(input int w, input logic [3:0] s, input logic [31:0] a,
                                 input logic [31:0] b, input exp_t prev, output int lat);
    exp_t        e;
    longint      ua, ub, full, lim, sres, cin;
    logic [31:0] mask, fv;
    logic [63:0] p;
    logic        c, v, zf;
    int          k;
    mask = (32'h1 << w) - 32'h1;
    ua   = longint'({32'h0, a});
    ub   = longint'({32'h0, b});
    lim  = longint'(1) << (w - 1);
    e    = prev;
    lat  = 0;
    c    = prev.flags[3];
    v    = 1'b0;
    fv   = a;
    case (s)
      4'h1, 4'h2: fv = b;
      4'h3: fv = a & b;
      4'h4: fv = a | b;
      4'h5: fv = a ^ b;
      4'h6: fv = ~b & mask;
      4'h7, 4'hd: begin
        full = ua - ub;
        c    = (ua < ub);
        sres = sx(w, a) - sx(w, b);
        v    = (sres >= lim) || (sres < -lim);
        fv   = 32'(full) & mask;
      end
      4'h8, 4'hb: begin
        cin  = (s == 4'h8) ? longint'(prev.flags[3]) : 0;
        full = ua + ub + cin;
        c    = (full >= (longint'(1) << w));
        sres = sx(w, a) + sx(w, b) + cin;
        v    = (sres >= lim) || (sres < -lim);
        fv   = 32'(full) & mask;
      end
      4'h9, 4'ha: begin
        k = (int'(b) > w) ? w : int'(b);
        c = 1'b0;
        if (k > 0) begin
          lat = k;
          if (s == 4'h9) begin
            fv = (a << k) & mask;
            c  = a[w-k];
          end else begin
            fv = a >> k;
            c  = a[k-1];
          end
        end
      end
      4'hc: begin
        p    = {32'h0, a} * {32'h0, b};
        fv   = 32'(p) & mask;
        e.hi = 32'(p >> w);
        c    = (e.hi != 0);
        lat  = w;
      end
      default: fv = a;
    endcase
    zf = (s == 4'hc) ? (e.hi == 0 && fv == 0) : (fv == 0);
    if (s != 4'hd) e.res = fv;
    e.flags = {c, zf, fv[w-1], v};
    return e;
  endfunction

  // Issue one op, push its expectation, optionally poke start while busy
  task automatic issue(input int w, input logic [3:0] s, input logic [31:0] a_in,
                       input logic [31:0] b_in, input int poke);
    exp_t        e;
    int          lat;
    logic [31:0] a, b;
    a = a_in & ((32'h1 << w) - 32'h1);
    b = b_in & ((32'h1 << w) - 32'h1);
    @(negedge clk);
    if (w == 8) begin
      e = model(8, s, a, b, m8, lat);
      m8 = e;
      e.cyc = cyc + 1 + lat;
      q8.push_back(e);
      start8 = 1'b1; sel8 = s; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      e = model(16, s, a, b, m16, lat);
      m16 = e;
      e.cyc = cyc + 1 + lat;
      q16.push_back(e);
      start16 = 1'b1; sel16 = s; a16 = a[15:0]; b16 = b[15:0];
    end
    @(posedge clk);
    #1;
    start8  = 1'b0;
    start16 = 1'b0;
    check_val((w == 8) ? "w8_busy_issue" : "w16_busy_issue",
              32'((w == 8) ? busy8 : busy16), 32'(lat > 0));
    if (poke > 0 && w == 8) begin
      repeat (poke) @(negedge clk);
      start8 = 1'b1; sel8 = 4'hb; a8 = 8'h11; b8 = 8'h22;
      @(negedge clk);
      start8 = 1'b0;
    end
    for (int i = 0; i < 40; i++) begin
      if (((w == 8) ? q8.size() : q16.size()) == 0) break;
      @(negedge clk);
    end
    if (w == 8) begin
      check_val("w8_pending_after_timeout", 32'(q8.size()), 32'h0);
      q8.delete();
    end else begin
      check_val("w16_pending_after_timeout", 32'(q16.size()), 32'h0);
      q16.delete();
    end
  endtask

  // Scoreboard pop for the 8-bit instance
  always @(posedge clk) begin
    #1;
    if (rst_n && done8) begin
      if (q8.size() == 0) begin
        check_val("w8_spurious_done", 32'(done8), 32'h0);
      end else begin
        e8 = q8.pop_front();
        check_val("w8_res", 32'(res8), e8.res);
        check_val("w8_res_hi", 32'(hi8), e8.hi);
        check_val("w8_flags", 32'(flags8), 32'(e8.flags));
        check_val("w8_done_cycle", 32'(cyc), 32'(e8.cyc));
        check_val("w8_busy_at_done", 32'(busy8), 32'h0);
      end
    end
  end

  // Scoreboard pop for the 16-bit instance
  always @(posedge clk) begin
    #1;
    if (rst_n && done16) begin
      if (q16.size() == 0) begin
        check_val("w16_spurious_done", 32'(done16), 32'h0);
      end else begin
        e16 = q16.pop_front();
        check_val("w16_res", 32'(res16), e16.res);
        check_val("w16_res_hi", 32'(hi16), e16.hi);
        check_val("w16_flags", 32'(flags16), 32'(e16.flags));
        check_val("w16_done_cycle", 32'(cyc), 32'(e16.cyc));
        check_val("w16_busy_at_done", 32'(busy16), 32'h0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    m8  = '{res: 32'h0, hi: 32'h0, flags: 4'h0, cyc: 0};
    m16 = '{res: 32'h0, hi: 32'h0, flags: 4'h0, cyc: 0};
    rst_n = 1'b0;
    start8 = 1'b0; sel8 = 4'h0; a8 = 8'h0; b8 = 8'h0;
    start16 = 1'b0; sel16 = 4'h0; a16 = 16'h0; b16 = 16'h0;
    repeat (2) @(negedge clk);
    check_val("rst_res", 32'(res8), 32'h0);
    check_val("rst_res_hi", 32'(hi8), 32'h0);
    check_val("rst_flags", 32'(flags8), 32'h0);
    check_val("rst_busy", 32'(busy8), 32'h0);
    check_val("rst_done", 32'(done8), 32'h0);
    rst_n = 1'b1;

    // arithmetic and compare
    issue(8, 4'hb, 32'hFF, 32'h01, 0);
    issue(8, 4'h8, 32'h10, 32'h20, 0);
    issue(8, 4'h7, 32'h80, 32'h01, 0);
    issue(8, 4'hd, 32'h05, 32'h09, 0);
    // logic and pass ops (C must hold)
    issue(8, 4'h3, 32'hF0, 32'h3C, 0);
    issue(8, 4'h4, 32'h81, 32'h02, 0);
    issue(8, 4'h5, 32'hAA, 32'hAA, 0);
    issue(8, 4'h6, 32'h00, 32'h0F, 0);
    issue(8, 4'h2, 32'h12, 32'h34, 0);
    issue(8, 4'hf, 32'h9C, 32'h34, 0);
    // shifts
    issue(8, 4'h9, 32'h81, 32'd3, 0);
    issue(8, 4'ha, 32'h81, 32'd0, 0);
    issue(8, 4'ha, 32'h81, 32'd200, 0);
    issue(8, 4'h9, 32'h81, 32'd8, 0);
    // multiply, with an ignored start while busy
    issue(8, 4'hc, 32'h00, 32'h37, 0);
    issue(8, 4'hc, 32'hFF, 32'hFF, 3);

    // reset in the middle of a multiply
    @(negedge clk);
    start8 = 1'b1; sel8 = 4'hc; a8 = 8'hA5; b8 = 8'h5A;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_val("mid_mul_busy", 32'(busy8), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst_res", 32'(res8), 32'h0);
    check_val("async_rst_res_hi", 32'(hi8), 32'h0);
    check_val("async_rst_flags", 32'(flags8), 32'h0);
    check_val("async_rst_busy", 32'(busy8), 32'h0);
    check_val("async_rst_done", 32'(done8), 32'h0);
    m8  = '{res: 32'h0, hi: 32'h0, flags: 4'h0, cyc: 0};
    m16 = '{res: 32'h0, hi: 32'h0, flags: 4'h0, cyc: 0};
    q8.delete();
    q16.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(8, 4'hc, 32'h0F, 32'h11, 0);
    issue(8, 4'hb, 32'h7F, 32'h01, 0);

    // random mix of every opcode
    for (int i = 0; i < 24; i++) begin
      issue(8, 4'($urandom_range(0, 15)), 32'($urandom_range(0, 255)),
            32'($urandom_range(0, 255)), 0);
    end

    // wider instance
    issue(16, 4'hb, 32'hFFFF, 32'h0001, 0);
    issue(16, 4'hc, 32'h0100, 32'h0100, 0);
    issue(16, 4'hc, 32'hFFFF, 32'hFFFF, 0);
    issue(16, 4'h7, 32'h0003, 32'h8000, 0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
